// File: rtl/timer_pkg.sv
// Shared definitions for the memory-mapped countdown timer: FSM states,
// register offsets, CTRL field positions and MODE codes.
package timer_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOAD = 2'd1,
    CNT  = 2'd2,
    INT  = 2'd3
  } state_t;

  localparam logic [1:0] OFF_CTRL   = 2'd0;
  localparam logic [1:0] OFF_PRESET = 2'd1;
  localparam logic [1:0] OFF_COUNT  = 2'd2;

  localparam int CTRL_EN      = 0;
  localparam int CTRL_MODE_LO = 1;
  localparam int CTRL_MODE_HI = 2;
  localparam int CTRL_IM      = 3;
  localparam int CTRL_PS_LO   = 4;
  localparam int CTRL_PS_HI   = 7;

  localparam logic [1:0] MODE_ONESHOT = 2'b00;
  localparam logic [1:0] MODE_RELOAD  = 2'b01;

  // Codes 10 and 11 fall back to one-shot behaviour.
  function automatic logic is_reload(input logic [1:0] mode);
    return mode == MODE_RELOAD;
  endfunction

endpackage

// File: rtl/timer_dev_if.sv
// Device-bus bundle between the CPU bridge (master) and a timer instance
// (slave): word address, write strobe/data, read data and interrupt.
interface timer_dev_if;
  logic [29:0] addr;
  logic        we;
  logic [31:0] wd;
  logic [31:0] rd;
  logic        irq;

  modport master (output addr, output we, output wd, input rd, input irq);
  modport slave  (input addr, input we, input wd, output rd, output irq);
endinterface

// File: rtl/timer_prescaler.sv
// Prescale counter producing a count tick once every P+1 cycles while the
// timer is in CNT; cleared on LOAD and on any CTRL write.
module timer_prescaler (
  input  logic       clk,
  input  logic       reset,
  input  logic       i_clr,
  input  logic       i_en,
  input  logic [3:0] i_p,
  output logic       o_tick
);

  logic [3:0] r_cnt;

  assign o_tick = (r_cnt == i_p);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_cnt <= 4'd0;
    end else if (i_clr) begin
      r_cnt <= 4'd0;
    end else if (i_en) begin
      r_cnt <= o_tick ? 4'd0 : r_cnt + 4'd1;
    end
  end

endmodule

// File: rtl/timer_dev.sv
// Programmable countdown timer on the external device bus (CTRL/PRESET/COUNT).
// Define TIMER_PRESCALER_EN to add the CTRL[7:4] prescaler.
module timer_dev
  import timer_pkg::*;
#(
  parameter logic [31:0] BASE_ADDR = 32'h0000_7F00
) (
  input  logic          clk,
  input  logic          reset,
  timer_dev_if.slave    bus
);

  logic [7:0]  r_ctrl;
  logic [31:0] r_preset;
  logic [31:0] r_count;
  state_t      r_state;
  logic        r_flag;

  logic        w_sel;
  logic [1:0]  w_off;
  logic        w_wr_ctrl;
  logic        w_wr_preset;
  logic        w_tick;
  logic [1:0]  w_mode;
  logic [31:0] w_rd;

  assign w_sel       = (bus.addr[29:2] == BASE_ADDR[31:4]);
  assign w_off       = bus.addr[1:0];
  assign w_wr_ctrl   = w_sel & bus.we & (w_off == OFF_CTRL);
  assign w_wr_preset = w_sel & bus.we & (w_off == OFF_PRESET);
  assign w_mode      = r_ctrl[CTRL_MODE_HI:CTRL_MODE_LO];

`ifdef TIMER_PRESCALER_EN
  localparam logic [7:0] CTRL_WMASK = 8'hFF;

  timer_prescaler u_prescaler (
    .clk    (clk),
    .reset  (reset),
    .i_clr  (w_wr_ctrl | (r_state == LOAD)),
    .i_en   (r_state == CNT),
    .i_p    (r_ctrl[CTRL_PS_HI:CTRL_PS_LO]),
    .o_tick (w_tick)
  );
`else
  localparam logic [7:0] CTRL_WMASK = 8'h0F;

  assign w_tick = 1'b1;
`endif

  // A CTRL/PRESET write overrides whatever the FSM would have done this edge.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_ctrl   <= 8'd0;
      r_preset <= 32'd0;
      r_count  <= 32'd0;
      r_state  <= IDLE;
      r_flag   <= 1'b0;
    end else if (w_wr_ctrl || w_wr_preset) begin
      if (w_wr_ctrl) begin
        r_ctrl <= bus.wd[7:0] & CTRL_WMASK;
      end
      if (w_wr_preset) begin
        r_preset <= bus.wd;
      end
      r_state <= IDLE;
      r_flag  <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          if (r_ctrl[CTRL_EN]) begin
            r_state <= LOAD;
          end
        end
        LOAD: begin
          r_count <= r_preset;
          r_state <= CNT;
        end
        CNT: begin
          if (!r_ctrl[CTRL_EN]) begin
            r_state <= IDLE;
          end else if (w_tick) begin
            if (r_count > 32'd1) begin
              r_count <= r_count - 32'd1;
            end else begin
              r_count <= 32'd0;
              r_state <= INT;
              r_flag  <= 1'b1;
            end
          end
        end
        INT: begin
          r_state <= IDLE;
          // Auto-reload keeps EN so the FSM restarts; the flag becomes a pulse.
          if (is_reload(w_mode)) begin
            r_flag <= 1'b0;
          end else begin
            r_ctrl[CTRL_EN] <= 1'b0;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  always_comb begin
    w_rd = 32'd0;
    if (w_sel) begin
      case (w_off)
        OFF_CTRL:   w_rd = {24'd0, r_ctrl};
        OFF_PRESET: w_rd = r_preset;
        OFF_COUNT:  w_rd = r_count;
        default:    w_rd = 32'd0;
      endcase
    end
  end

  assign bus.rd  = w_rd;
  assign bus.irq = r_flag & r_ctrl[CTRL_IM];

endmodule

// File: doc/timer_dev.md
# timer_dev

Memory-mapped programmable countdown timer on the processor's external device bus. It decodes the word address, write enable and write data the CPU drives toward the bridge. It returns read data on the shared read bus and raises an interrupt line that feeds one bit of the CPU's 6-bit hardware interrupt vector. The system instantiates two copies, at 0x0000_7F00 and 0x0000_7F10.

## Interface
- BASE_ADDR, 32'h0000_7F00, byte base of the 16-byte register window; bits [3:0] must be 0.
- clk  input  1  system clock; all state changes on the rising edge.
- reset  input  1  asynchronous, active-low reset.
- addr  input  30  word address, byte address bits [31:2].
- we  input  1  write strobe; the CPU already suppresses it when an exception cuts the instruction.
- wd  input  32  write data.
- rd  output  32  combinational read data; 0 when not selected.
- irq  output  1  interrupt request, level, active-high.

## Operation
- Select condition: addr[31:4] == BASE_ADDR[31:4]. Register offset is addr[3:2].
- Offset 0 is CTRL, read/write.
  - Bit 0, EN: count enable.
  - Bits [2:1], MODE: 00 = one-shot, 01 = auto-reload. Codes 10 and 11 behave as 00.
  - Bit 3, IM: interrupt mask, 1 = enabled.
  - Other bits are written-ignored and read 0.
- Offset 1 is PRESET, read/write, 32 bits.
- Offset 2 is COUNT, read-only. Writes to it are ignored.
- Offset 3 is reserved: reads 0, writes are ignored.
- Reset values: CTRL=0, PRESET=0, COUNT=0, state IDLE, flag=0, irq=0.
- State machine:
  - IDLE: if EN, go to LOAD.
  - LOAD: COUNT <= PRESET; go to CNT.
  - CNT, when EN=0: go to IDLE and hold COUNT.
  - CNT, when COUNT > 1: decrement on each tick.
  - CNT, when COUNT ≤ 1: COUNT <= 0 and go to INT. A PRESET of 0 or 1 therefore reaches INT after one CNT cycle.
  - INT: set flag on entry, then go to IDLE. In MODE 00, the INT→IDLE edge also clears EN. In MODE 01, EN stays set, so the timer reloads.
- Interrupt: irq = flag & IM.
  - MODE 00: flag holds until a write to CTRL or PRESET.
  - MODE 01: flag clears on the INT→IDLE edge, giving a single-cycle pulse.
- Write side effects: any write to CTRL or PRESET forces state to IDLE and clears flag. COUNT is unchanged.
- Simultaneous events: a bus write on the same edge as an FSM update wins. The written register takes the bus value and the state goes to IDLE.
- Reset asserted mid-count returns every register to its reset value immediately.

## Timing
- Write latency: a register write is visible on rd in the cycle after the write edge.
- Reads have zero latency.
- Count sequence, with PRESET=N ≥ 1 and EN written at edge E0:
  - LOAD is entered at E1.
  - COUNT=N after E2.
  - COUNT=N−k after E2+k.
  - INT is entered at E(N+2); irq rises after that edge.
- Auto-reload period: N+3 cycles (INT→IDLE→LOAD→CNT overhead).
- irq is registered, so it carries no combinational path from the bus.

## Configuration
- TIMER_PRESCALER_EN defined:
  - CTRL[7:4] = P is writable and readable.
  - In CNT, COUNT changes only when the prescale counter reaches P, i.e. once every P+1 cycles.
  - The prescale counter clears in LOAD and on any CTRL write.
  - With P=0 the timing is identical to the undefined case.
- TIMER_PRESCALER_EN undefined: CTRL[7:4] reads 0, and COUNT ticks every CNT cycle.

## Structure
- timer_pkg holds:
  - the state enum (IDLE, LOAD, CNT, INT);
  - offset constants OFF_CTRL=0, OFF_PRESET=1, OFF_COUNT=2;
  - CTRL bit positions;
  - MODE codes.
- One sub-module, timer_prescaler. It is instantiated only under TIMER_PRESCALER_EN and outputs the tick enable. Without the macro, the tick enable is tied to 1.

## Test plan
- Reset, then read all four offsets → 0. irq=0.
- One-shot: write PRESET=5, then CTRL=0x9 → COUNT reads 5,4,3,2,1,0 on successive cycles from E2. irq=1 from E7 and stays 1. Reading CTRL afterwards returns 0x8.
- Auto-reload: PRESET=3, CTRL=0xB → irq pulses exactly one cycle every 6 cycles, four consecutive times.
- Mask: PRESET=2, CTRL=0x1 → INT is reached and irq stays 0. A later write of CTRL=0x8 → irq stays 0 because the write cleared flag.
- Disable and collision:
  - Write CTRL=0 while COUNT=7 → COUNT holds 7.
  - Write PRESET on the edge COUNT would reach 0 → no INT, state IDLE.
  - A write to offset 2 leaves COUNT unchanged.
- Decode: with BASE_ADDR=0x7F10, accesses at 0x7F00 → rd=0 and no register change. Asynchronous reset pulsed mid-count → all registers 0 without a clock edge.
